reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular reorder buffer at the allocation end of the backend. It grants ROB entries to the instruction issuer and records each entry's destination architectural register. It captures results from the common data bus (CDB), answers the issuer's CDB listen queries with hit/data, and retires completed entries in order to the architectural register file.

## Interface
- `ROB_ENTRY`, 4: number of entries; must be a power of two, ≥ 2.
- `ARCH_ENTRY`, 32: number of architectural registers.
- `DATA_WIDTH`, 32: result data width.
- `NUM_LSN`, 4: number of listen ports. Index 0 = rs1_fetch, 1 = rs2_fetch, 2 = rs1_issue, 3 = rs2_issue.
- `ROB_ENTRY_LOG2`, `$clog2(ROB_ENTRY)`; `ARCH_ENTRY_LOG2`, `$clog2(ARCH_ENTRY)`.

Ports:
- `CLK` in 1: single clock.
- `RST` in 1: reset; synchronous, active-high.
- `flush` in 1: discard all entries.
- `rob_request` in 1: issuer allocation request; held until granted.
- `rob_arch_id` in `ARCH_ENTRY_LOG2`: destination register of the requesting instruction.
- `rob_grant` out 1: allocation accepted this cycle.
- `rob_alias_id` out `ROB_ENTRY_LOG2`: entry being allocated (tail pointer).
- `cdb_valid` in 1: CDB result broadcast.
- `cdb_id` in `ROB_ENTRY_LOG2`: producing entry.
- `cdb_data` in `DATA_WIDTH`: result value.
- `cdb_lsn_request` in `NUM_LSN`: listen query valid, one bit per port.
- `cdb_lsn_id` in `NUM_LSN*ROB_ENTRY_LOG2`: queried entry per port; port k is at bits `[k*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2]`.
- `cdb_lsn_hit` out `NUM_LSN`: result available, one bit per port.
- `cdb_lsn_data` out `NUM_LSN*DATA_WIDTH`: result per port.
- `cmt_valid` out 1: head entry is ready to retire.
- `cmt_ready` in 1: register file accepts the commit.
- `cmt_arch_id` out `ARCH_ENTRY_LOG2`: commit destination register.
- `cmt_alias_id` out `ROB_ENTRY_LOG2`: committing entry, used by the RAT to clear a matching alias.
- `cmt_data` out `DATA_WIDTH`: commit value.
- `rob_full` out 1: `count == ROB_ENTRY`.
- `rob_empty` out 1: `count == 0`.

## Operation
- **Per-entry state:** `busy`, `done`, `arch_id`, `data`. Global state: `head`, `tail` (`ROB_ENTRY_LOG2` bits each, wrap naturally), and `count` (`ROB_ENTRY_LOG2+1` bits).
- **Allocation:**
  - `rob_grant = rob_request & ~rob_full & ~flush`.
  - `rob_alias_id = tail`.
  - On grant: `busy[tail]<=1`, `done[tail]<=0`, `arch_id[tail]<=rob_arch_id`, `tail<=tail+1`.
- **Writeback:**
  - When `cdb_valid & busy[cdb_id] & ~done[cdb_id]`: `done<=1`, `data<=cdb_data`.
  - A write to a non-busy or already-done entry is ignored.
- **Listen port k (combinational):**
  - `hit_k = req_k & busy[id_k] & (done[id_k] | (cdb_valid & cdb_id==id_k))`.
  - `data_k` = `cdb_data` on a same-cycle CDB match, otherwise `data[id_k]`.
  - `data_k` is don't-care when `hit_k=0`; the bench checks it only on hit.
- **Commit:**
  - `cmt_valid = busy[head] & done[head] & ~flush`.
  - On `cmt_valid & cmt_ready`: `busy[head]<=0`, `head<=head+1`.
- **Count:** +1 on grant only, −1 on commit only, unchanged when both occur in the same cycle.
- **Flush:** all `busy<=0`, `head=tail=count=0`. Flush overrides grant, writeback and commit that cycle. `data` and `arch_id` are not cleared.
- **Reset:** same as flush, and additionally `done`, `data` and `arch_id` clear to 0.
  - Output values after reset: `rob_grant=0`, `rob_alias_id=0`, `cmt_valid=0`, `cdb_lsn_hit=0`, `rob_empty=1`, `rob_full=0`.

## Timing
- Grant is combinational, in the same cycle as the request. The issuer samples `rob_alias_id` in that same cycle.
- CDB-to-listen bypass has zero latency. A result stored from the CDB is visible from the stored copy on the next cycle.
- Earliest commit is the cycle after writeback. Throughput is one allocation and one commit per cycle.
- When full, no grant is given, even if a commit frees an entry in the same cycle. The freed entry is grantable on the next cycle.
- A CDB write and a commit cannot target the same entry in the same cycle: commit requires `done`, and a write to a done entry is ignored.
- `RST` or `flush` asserted mid-stream: the next cycle shows the empty state. Grants and commits in the flush cycle are suppressed.

## Structure
- `rob_pkg` holds:
  - listen-port index constants `LSN_RS1_FETCH=0`, `LSN_RS2_FETCH=1`, `LSN_RS1_ISSUE=2`, `LSN_RS2_ISSUE=3`;
  - the ROB entry field layout, shared with the issuer and the RAT.
- Sub-module `rob_lsn_port`: a single combinational listen lookup (hit/bypass mux), instantiated `NUM_LSN` times in a generate loop.

## Test plan
- **Fill:** reset, then hold `rob_request` with arch_ids 5, 6, 7, 8, 9.
  - Grants on 4 consecutive cycles with `rob_alias_id` 0, 1, 2, 3.
  - `rob_full=1` after the fourth grant; the fifth request gets no grant.
- **Out-of-order writeback:** CDB writes id2=0xB, then id0=0xA.
  - Commit of entry 0 (arch 5, 0xA) the cycle after the id0 write.
  - Entry 1 blocks commit until it is written; entry 2 commits right after entry 1.
- **Bypass:** port 2 queries id1 in the same cycle as CDB id1 = 0x1234.
  - `hit[2]=1`, data 0x1234.
  - The following cycle, the hit comes from the stored value.
- **Full turnover:** ROB full, commit and request in the same cycle.
  - No grant that cycle, count becomes 3.
  - The next cycle grants `rob_alias_id=0` (wrap-around).
- **Stall:** `cmt_ready=0` for 3 cycles with the head done.
  - `cmt_valid` held with stable `arch_id`/`data`.
  - Retires on the cycle `cmt_ready` rises.
- **Flush:** 3 busy entries, then `flush`.
  - Next cycle `rob_empty=1`, `cmt_valid=0`, a listen to id0 misses, and the next grant is `rob_alias_id=0`.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer, its listen ports, the issuer and the RAT.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rob_pkg;

    // Listen-port slots on cdb_lsn_* buses
    localparam int LSN_RS1_FETCH = 0;
    localparam int LSN_RS2_FETCH = 1;
    localparam int LSN_RS1_ISSUE = 2;
    localparam int LSN_RS2_ISSUE = 3;

    // Default geometry of one ROB entry
    localparam int ROB_ENTRY_LOG2_DEF  = 2;
    localparam int ARCH_ENTRY_LOG2_DEF = 5;
    localparam int DATA_WIDTH_DEF      = 32;

    // Field layout of a ROB entry, as seen by the issuer and the RAT
    typedef struct packed {
        logic                           busy;
        logic                           done;
        logic [ARCH_ENTRY_LOG2_DEF-1:0] arch_id;
        logic [DATA_WIDTH_DEF-1:0]      data;
    } rob_entry_t;

endpackage

// File: rtl/rob_lsn_port.sv
// One CDB listen lookup: reports whether an entry's result is available, with same-cycle CDB bypass.
// Latency: purely combinational, zero cycles.
// Backpressure: none; answers every query in the cycle it is asked.
// Ports: req/id = query; busy/done/data = ROB entry state; cdb_* = live broadcast; hit/hit_data = answer.
module rob_lsn_port
    import rob_pkg::*;
#(
    parameter  int ROB_ENTRY      = 4,
    parameter  int DATA_WIDTH     = 32,
    localparam int ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY)
) (
    input  logic                                 req,
    input  logic [ROB_ENTRY_LOG2-1:0]            id,
    input  logic [ROB_ENTRY-1:0]                 busy,
    input  logic [ROB_ENTRY-1:0]                 done,
    input  logic [ROB_ENTRY-1:0][DATA_WIDTH-1:0] data,
    input  logic                                 cdb_valid,
    input  logic [ROB_ENTRY_LOG2-1:0]            cdb_id,
    input  logic [DATA_WIDTH-1:0]                cdb_data,
    output logic                                 hit,
    output logic [DATA_WIDTH-1:0]                hit_data
);

    logic cdb_match;

    // A result on the CDB right now is as good as a stored one
    assign cdb_match = cdb_valid && (cdb_id == id);
    assign hit       = req && busy[id] && (done[id] || cdb_match);
    assign hit_data  = cdb_match ? cdb_data : data[id];

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates entries, captures CDB results, answers listen queries, retires in order.
// Latency: grant and listen are combinational; a result commits no earlier than the cycle after writeback.
// Backpressure: no grant while full (even if a commit frees a slot that cycle); head holds while cmt_ready=0.
// Ports: rob_* = allocation, cdb_* = writeback and listen, cmt_* = retirement, rob_full/rob_empty = status.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROB_ENTRY       = 4,
    parameter int ARCH_ENTRY      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_LSN         = 4,
    parameter int ROB_ENTRY_LOG2  = $clog2(ROB_ENTRY),
    parameter int ARCH_ENTRY_LOG2 = $clog2(ARCH_ENTRY)
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              flush,
    input  logic                              rob_request,
    input  logic [ARCH_ENTRY_LOG2-1:0]        rob_arch_id,
    output logic                              rob_grant,
    output logic [ROB_ENTRY_LOG2-1:0]         rob_alias_id,
    input  logic                              cdb_valid,
    input  logic [ROB_ENTRY_LOG2-1:0]         cdb_id,
    input  logic [DATA_WIDTH-1:0]             cdb_data,
    input  logic [NUM_LSN-1:0]                cdb_lsn_request,
    input  logic [NUM_LSN*ROB_ENTRY_LOG2-1:0] cdb_lsn_id,
    output logic [NUM_LSN-1:0]                cdb_lsn_hit,
    output logic [NUM_LSN*DATA_WIDTH-1:0]     cdb_lsn_data,
    output logic                              cmt_valid,
    input  logic                              cmt_ready,
    output logic [ARCH_ENTRY_LOG2-1:0]        cmt_arch_id,
    output logic [ROB_ENTRY_LOG2-1:0]         cmt_alias_id,
    output logic [DATA_WIDTH-1:0]             cmt_data,
    output logic                              rob_full,
    output logic                              rob_empty
);

    localparam logic [ROB_ENTRY_LOG2:0] FULL_COUNT = ROB_ENTRY[ROB_ENTRY_LOG2:0];

    logic [ROB_ENTRY-1:0]                      busy;
    logic [ROB_ENTRY-1:0]                      done;
    logic [ROB_ENTRY-1:0][ARCH_ENTRY_LOG2-1:0] arch_id;
    logic [ROB_ENTRY-1:0][DATA_WIDTH-1:0]      data;
    logic [ROB_ENTRY_LOG2-1:0]                 head;
    logic [ROB_ENTRY_LOG2-1:0]                 tail;
    logic [ROB_ENTRY_LOG2:0]                   count;

    logic writeback;
    logic commit;

    // Full is judged on the registered count, so a slot freed by this cycle's commit is not re-granted until next cycle
    assign rob_full     = (count == FULL_COUNT);
    assign rob_empty    = (count == '0);
    assign rob_grant    = rob_request && !rob_full && !flush;
    assign rob_alias_id = tail;

    // Late or duplicate results (entry freed or already done) are dropped
    assign writeback = cdb_valid && busy[cdb_id] && !done[cdb_id];

    assign cmt_valid    = busy[head] && done[head] && !flush;
    assign commit       = cmt_valid && cmt_ready;
    assign cmt_arch_id  = arch_id[head];
    assign cmt_alias_id = head;
    assign cmt_data     = data[head];

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy    <= '0;
            done    <= '0;
            arch_id <= '0;
            data    <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else if (flush) begin
            // Stale arch_id/data/done are left in place; busy=0 hides them
            busy  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Grant targets a free slot and writeback a busy one, so they never collide
            if (rob_grant) begin
                busy[tail]    <= 1'b1;
                done[tail]    <= 1'b0;
                arch_id[tail] <= rob_arch_id;
                tail          <= tail + 1'b1;
            end
            if (writeback) begin
                done[cdb_id] <= 1'b1;
                data[cdb_id] <= cdb_data;
            end
            if (commit) begin
                busy[head] <= 1'b0;
                head       <= head + 1'b1;
            end
            case ({rob_grant, commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_LSN; k++) begin : g_lsn
        rob_lsn_port #(
            .ROB_ENTRY  (ROB_ENTRY),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lsn (
            .req       (cdb_lsn_request[k]),
            .id        (cdb_lsn_id[k*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2]),
            .busy      (busy),
            .done      (done),
            .data      (data),
            .cdb_valid (cdb_valid),
            .cdb_id    (cdb_id),
            .cdb_data  (cdb_data),
            .hit       (cdb_lsn_hit[k]),
            .hit_data  (cdb_lsn_data[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, hand sequences, random run vs queue model.
// Latency: n/a.
// Backpressure: exercised through cmt_ready stalls and full-buffer requests.
module tb_reorder_buffer;

    logic         CLK = 1'b0;
    logic         RST;
    logic         flush;
    logic         rob_request;
    logic [4:0]   rob_arch_id;
    logic         rob_grant;
    logic [1:0]   rob_alias_id;
    logic         cdb_valid;
    logic [1:0]   cdb_id;
    logic [31:0]  cdb_data;
    logic [3:0]   cdb_lsn_request;
    logic [7:0]   cdb_lsn_id;
    logic [3:0]   cdb_lsn_hit;
    logic [127:0] cdb_lsn_data;
    logic         cmt_valid;
    logic         cmt_ready;
    logic [4:0]   cmt_arch_id;
    logic [1:0]   cmt_alias_id;
    logic [31:0]  cmt_data;
    logic         rob_full;
    logic         rob_empty;

    reorder_buffer dut (
        .CLK             (CLK),
        .RST             (RST),
        .flush           (flush),
        .rob_request     (rob_request),
        .rob_arch_id     (rob_arch_id),
        .rob_grant       (rob_grant),
        .rob_alias_id    (rob_alias_id),
        .cdb_valid       (cdb_valid),
        .cdb_id          (cdb_id),
        .cdb_data        (cdb_data),
        .cdb_lsn_request (cdb_lsn_request),
        .cdb_lsn_id      (cdb_lsn_id),
        .cdb_lsn_hit     (cdb_lsn_hit),
        .cdb_lsn_data    (cdb_lsn_data),
        .cmt_valid       (cmt_valid),
        .cmt_ready       (cmt_ready),
        .cmt_arch_id     (cmt_arch_id),
        .cmt_alias_id    (cmt_alias_id),
        .cmt_data        (cmt_data),
        .rob_full        (rob_full),
        .rob_empty       (rob_empty)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lsn_dat(input int k);
        return cdb_lsn_data[k*32 +: 32];
    endfunction

    function automatic logic [1:0] lsn_id(input int k);
        return cdb_lsn_id[k*2 +: 2];
    endfunction

    task automatic idle_inputs();
        flush = 1'b0; rob_request = 1'b0; rob_arch_id = '0;
        cdb_valid = 1'b0; cdb_id = '0; cdb_data = '0;
        cdb_lsn_request = '0; cdb_lsn_id = '0; cmt_ready = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Directed vector: inputs, then expected outputs. ldat applies to every port expected to hit.
    typedef struct {
        int fl, rq, arch, cv, cid, cdat, lreq, lid, crdy;
        int g, al, cvo, cal, carch, cdato, hit, ldat, full, empty;
    } tv_t;
    tv_t tv[$];

    // Reference model: the ROB as an ordered list of live entries
    typedef struct {
        int          aid;
        int          arch;
        bit          done;
        logic [31:0] data;
    } m_ent_t;
    m_ent_t mq[$];
    int     m_tail;

    function automatic int mfind(input int id);
        foreach (mq[i]) if (mq[i].aid == id) return i;
        return -1;
    endfunction

    initial begin
        tv_t v;
        idle_inputs();
        RST = 1'b1;
        repeat (2) next_cycle();
        RST = 1'b0;
        cdb_lsn_request = 4'hF;
        cdb_lsn_id = 8'hE4;
        #2;
        chk("reset grant", 32'(rob_grant), 0);
        chk("reset alias", 32'(rob_alias_id), 0);
        chk("reset cmt_valid", 32'(cmt_valid), 0);
        chk("reset hit", 32'(cdb_lsn_hit), 0);
        chk("reset empty", 32'(rob_empty), 1);
        chk("reset full", 32'(rob_full), 0);
        next_cycle();

        //          fl rq arch cv cid cdat     lreq     lid   crdy  g al cvo cal carch cdato    hit      ldat     full empty
        tv.push_back('{0, 1, 5,  0, 0, 0,       0,       0,    1,    1, 0, 0, 0, 0,  0,       0,       0,       0, 1}); // fill
        tv.push_back('{0, 1, 6,  0, 0, 0,       0,       0,    1,    1, 1, 0, 0, 0,  0,       0,       0,       0, 0});
        tv.push_back('{0, 1, 7,  0, 0, 0,       0,       0,    1,    1, 2, 0, 0, 0,  0,       0,       0,       0, 0});
        tv.push_back('{0, 1, 8,  0, 0, 0,       0,       0,    1,    1, 3, 0, 0, 0,  0,       0,       0,       0, 0});
        tv.push_back('{0, 1, 9,  0, 0, 0,       0,       0,    1,    0, 0, 0, 0, 0,  0,       0,       0,       1, 0}); // full, no grant
        tv.push_back('{0, 0, 0,  1, 2, 'hB,     'b0001,  'h02, 1,    0, 0, 0, 0, 0,  0,       'b0001,  'hB,     1, 0}); // write id2
        tv.push_back('{0, 0, 0,  1, 0, 'hA,     'b0010,  'h00, 1,    0, 0, 0, 0, 0,  0,       'b0010,  'hA,     1, 0}); // write id0
        tv.push_back('{0, 1, 10, 0, 0, 0,       'b0100,  'h20, 1,    0, 0, 1, 0, 5,  'hA,     'b0100,  'hB,     1, 0}); // commit+req while full
        tv.push_back('{0, 1, 10, 1, 1, 'h1234,  'b1100,  'hD0, 1,    1, 0, 0, 0, 0,  0,       'b0100,  'h1234,  0, 0}); // wrap grant + bypass
        tv.push_back('{0, 0, 0,  0, 0, 0,       'b0100,  'h10, 0,    0, 1, 1, 1, 6,  'h1234,  'b0100,  'h1234,  1, 0}); // stored hit, stall
        tv.push_back('{0, 0, 0,  0, 0, 0,       0,       0,    0,    0, 1, 1, 1, 6,  'h1234,  0,       0,       1, 0});
        tv.push_back('{0, 0, 0,  0, 0, 0,       0,       0,    0,    0, 1, 1, 1, 6,  'h1234,  0,       0,       1, 0});
        tv.push_back('{0, 0, 0,  0, 0, 0,       0,       0,    1,    0, 1, 1, 1, 6,  'h1234,  0,       0,       1, 0}); // retire
        tv.push_back('{0, 0, 0,  0, 0, 0,       'b1000,  'h40, 1,    0, 1, 1, 2, 7,  'hB,     0,       0,       0, 0}); // entry 2 follows
        tv.push_back('{0, 0, 0,  1, 2, 'hFF,    'b0001,  'h02, 1,    0, 1, 0, 0, 0,  0,       0,       0,       0, 0}); // write to free entry
        tv.push_back('{0, 1, 11, 1, 3, 'h33,    'b0010,  'h0C, 1,    1, 1, 0, 0, 0,  0,       'b0010,  'h33,    0, 0});
        tv.push_back('{1, 1, 12, 0, 0, 0,       0,       0,    1,    0, 2, 0, 0, 0,  0,       0,       0,       0, 0}); // flush
        tv.push_back('{0, 1, 12, 0, 0, 0,       'b0001,  'h00, 1,    1, 0, 0, 0, 0,  0,       0,       0,       0, 1});
        tv.push_back('{0, 0, 0,  0, 0, 0,       'b0001,  'h00, 1,    0, 1, 0, 0, 0,  0,       0,       0,       0, 0});

        for (int i = 0; i < tv.size(); i++) begin
            v = tv[i];
            flush = 1'(v.fl); rob_request = 1'(v.rq); rob_arch_id = 5'(v.arch);
            cdb_valid = 1'(v.cv); cdb_id = 2'(v.cid); cdb_data = 32'(v.cdat);
            cdb_lsn_request = 4'(v.lreq); cdb_lsn_id = 8'(v.lid); cmt_ready = 1'(v.crdy);
            #2;
            chk($sformatf("row%0d grant", i), 32'(rob_grant), 32'(v.g));
            chk($sformatf("row%0d alias", i), 32'(rob_alias_id), 32'(v.al));
            chk($sformatf("row%0d cmt_valid", i), 32'(cmt_valid), 32'(v.cvo));
            if (v.cvo != 0) begin
                chk($sformatf("row%0d cmt_alias", i), 32'(cmt_alias_id), 32'(v.cal));
                chk($sformatf("row%0d cmt_arch", i), 32'(cmt_arch_id), 32'(v.carch));
                chk($sformatf("row%0d cmt_data", i), cmt_data, 32'(v.cdato));
            end
            chk($sformatf("row%0d hit", i), 32'(cdb_lsn_hit), 32'(v.hit));
            for (int k = 0; k < 4; k++)
                if (v.hit[k]) chk($sformatf("row%0d lsn%0d data", i, k), lsn_dat(k), 32'(v.ldat));
            chk($sformatf("row%0d full", i), 32'(rob_full), 32'(v.full));
            chk($sformatf("row%0d empty", i), 32'(rob_empty), 32'(v.empty));
            next_cycle();
        end

        // Mid-stream reset with a busy entry present
        idle_inputs();
        RST = 1'b1; rob_request = 1'b1; rob_arch_id = 5'd1;
        next_cycle();
        RST = 1'b0; rob_request = 1'b0; cdb_lsn_request = 4'hF; cdb_lsn_id = 8'h00;
        #2;
        chk("rst empty", 32'(rob_empty), 1);
        chk("rst cmt_valid", 32'(cmt_valid), 0);
        chk("rst hit", 32'(cdb_lsn_hit), 0);
        chk("rst alias", 32'(rob_alias_id), 0);
        next_cycle();

        // Second CDB write to a done entry: bypassed on the wire, never stored
        idle_inputs();
        rob_request = 1'b1; rob_arch_id = 5'd3;
        #2;
        chk("dup grant", 32'(rob_grant), 1);
        next_cycle();
        idle_inputs();
        cdb_valid = 1'b1; cdb_id = 2'd0; cdb_data = 32'h11;
        next_cycle();
        cdb_data = 32'h22; cmt_ready = 1'b0;
        cdb_lsn_request = 4'b0010; cdb_lsn_id = 8'h00;
        #2;
        chk("dup bypass hit", 32'(cdb_lsn_hit[1]), 1);
        chk("dup bypass data", lsn_dat(1), 32'h22);
        chk("dup cmt_data live", cmt_data, 32'h11);
        next_cycle();
        cdb_valid = 1'b0;
        #2;
        chk("dup stored data", lsn_dat(1), 32'h11);
        chk("dup cmt_data kept", cmt_data, 32'h11);
        cmt_ready = 1'b1;
        next_cycle();
        #2;
        chk("dup retired empty", 32'(rob_empty), 1);
        next_cycle();

        // Randomized run against the queue model
        idle_inputs();
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        mq.delete();
        m_tail = 0;
        for (int c = 0; c < 600; c++) begin
            bit e_full, e_empty, e_grant, e_cv;
            flush           = ($urandom_range(0, 29) == 0);
            rob_request     = 1'($urandom_range(0, 1));
            rob_arch_id     = 5'($urandom);
            cdb_valid       = 1'($urandom_range(0, 1));
            cdb_id          = 2'($urandom);
            cdb_data        = $urandom;
            cdb_lsn_request = 4'($urandom);
            cdb_lsn_id      = 8'($urandom);
            cmt_ready       = ($urandom_range(0, 9) < 7);
            #2;
            e_full  = (mq.size() == 4);
            e_empty = (mq.size() == 0);
            e_grant = rob_request && !e_full && !flush;
            e_cv    = !e_empty && mq[0].done && !flush;
            chk("rnd grant", 32'(rob_grant), 32'(e_grant));
            chk("rnd alias", 32'(rob_alias_id), 32'(m_tail));
            chk("rnd full", 32'(rob_full), 32'(e_full));
            chk("rnd empty", 32'(rob_empty), 32'(e_empty));
            chk("rnd cmt_valid", 32'(cmt_valid), 32'(e_cv));
            if (e_cv) begin
                chk("rnd cmt_alias", 32'(cmt_alias_id), 32'(mq[0].aid));
                chk("rnd cmt_arch", 32'(cmt_arch_id), 32'(mq[0].arch));
                chk("rnd cmt_data", cmt_data, mq[0].data);
            end
            for (int k = 0; k < 4; k++) begin
                int j;
                bit byp, e_hit;
                j     = mfind(int'(lsn_id(k)));
                byp   = cdb_valid && (cdb_id == lsn_id(k));
                e_hit = cdb_lsn_request[k] && (j >= 0) && (byp || mq[j].done);
                chk($sformatf("rnd lsn%0d hit", k), 32'(cdb_lsn_hit[k]), 32'(e_hit));
                if (e_hit)
                    chk($sformatf("rnd lsn%0d data", k), lsn_dat(k), byp ? cdb_data : mq[j].data);
            end
            if (flush) begin
                mq.delete();
                m_tail = 0;
            end else begin
                if (cdb_valid) begin
                    int j;
                    j = mfind(int'(cdb_id));
                    if (j >= 0 && !mq[j].done) begin
                        mq[j].done = 1'b1;
                        mq[j].data = cdb_data;
                    end
                end
                if (e_cv && cmt_ready) void'(mq.pop_front());
                if (e_grant) begin
                    mq.push_back('{aid: m_tail, arch: int'(rob_arch_id), done: 1'b0, data: 32'h0});
                    m_tail = (m_tail + 1) % 4;
                end
            end
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
